// File: rtl/pm_domain_seq_if.sv
// Request/acknowledge and control bundle between the power controller and the domain sequencer.
// master drives the requests and switch acknowledge; slave (the sequencer) drives the controls.
interface pm_domain_seq_if;
  logic pwr_down_req;
  logic pwr_up_req;
  logic sw_ack;
  logic clk_sel;
  logic clk_en;
  logic iso_en;
  logic ret_save;
  logic ret_restore;
  logic sw_en;
  logic busy;
  logic done;
  logic err;

  modport master (
    output pwr_down_req, pwr_up_req, sw_ack,
    input  clk_sel, clk_en, iso_en, ret_save, ret_restore, sw_en, busy, done, err
  );

  modport slave (
    input  pwr_down_req, pwr_up_req, sw_ack,
    output clk_sel, clk_en, iso_en, ret_save, ret_restore, sw_en, busy, done, err
  );
endinterface

// File: rtl/pm_domain_seq.sv
// Power-domain sequencer: orders clock switch, gating, isolation, retention and power switch
// for domain power-down/up, with a timeout on the synchronised power-switch acknowledge.
module pm_domain_seq #(
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned ACK_TIMEOUT   = 200
) (
  input logic             clk,
  input logic             rst_n,
  pm_domain_seq_if.slave  bus
);

  typedef enum logic [3:0] {
    StOn, StClkSw, StGate, StIso, StSave, StSwOff,
    StOff, StSwOn, StRestore, StDeiso, StUngate, StClkRet
  } state_e;

  // Counter is loaded with limit-1 so a state with limit N lasts exactly N cycles.
  localparam logic [CNT_W-1:0] SettleLoad = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] AckLoad    = CNT_W'(ACK_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_zero;
  logic             timeout;
  logic             ack_meta_q, ack_s_q;

  logic clk_sel_q, clk_sel_d;
  logic clk_en_q, clk_en_d;
  logic iso_en_q, iso_en_d;
  logic ret_save_q, ret_save_d;
  logic ret_restore_q, ret_restore_d;
  logic sw_en_q, sw_en_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q, err_d;

  assign cnt_zero = (cnt_q == '0);

  // State, counter, synchroniser and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StOn;
      cnt_q         <= '0;
      ack_meta_q    <= 1'b1;
      ack_s_q       <= 1'b1;
      clk_sel_q     <= 1'b0;
      clk_en_q      <= 1'b1;
      iso_en_q      <= 1'b0;
      ret_save_q    <= 1'b0;
      ret_restore_q <= 1'b0;
      sw_en_q       <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ack_meta_q    <= bus.sw_ack;
      ack_s_q       <= ack_meta_q;
      clk_sel_q     <= clk_sel_d;
      clk_en_q      <= clk_en_d;
      iso_en_q      <= iso_en_d;
      ret_save_q    <= ret_save_d;
      ret_restore_q <= ret_restore_d;
      sw_en_q       <= sw_en_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    unique case (state_q)
      StOn:      if (bus.pwr_down_req) state_d = StClkSw;
      StClkSw:   if (cnt_zero) state_d = StGate;
      StGate:    state_d = StIso;
      StIso:     state_d = StSave;
      StSave:    if (cnt_zero) state_d = StSwOff;
      StSwOff: begin
        if (!ack_s_q) begin
          state_d = StOff;
        end else if (cnt_zero) begin
          state_d = StOff;
          timeout = 1'b1;
        end
      end
      StOff:     if (bus.pwr_up_req) state_d = StSwOn;
      StSwOn: begin
        if (ack_s_q) begin
          state_d = StRestore;
        end else if (cnt_zero) begin
          state_d = StOff;
          timeout = 1'b1;
        end
      end
      StRestore: if (cnt_zero) state_d = StDeiso;
      StDeiso:   state_d = StUngate;
      StUngate:  state_d = StClkRet;
      StClkRet:  if (cnt_zero) state_d = StOn;
      default:   state_d = StOn;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      unique case (state_d)
        StClkSw, StSave, StRestore, StClkRet: cnt_d = SettleLoad;
        StSwOff, StSwOn:                      cnt_d = AckLoad;
        default:                              cnt_d = '0;
      endcase
    end else if (!cnt_zero) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Output decode from the next state; unlisted outputs hold their previous value
  always_comb begin
    clk_sel_d     = clk_sel_q;
    clk_en_d      = clk_en_q;
    iso_en_d      = iso_en_q;
    sw_en_d       = sw_en_q;
    ret_save_d    = (state_d == StSave);
    ret_restore_d = (state_d == StRestore);
    busy_d        = !(state_d inside {StOn, StOff});
    done_d        = (state_d != state_q) && (state_d inside {StOn, StOff});
    err_d         = err_q | timeout;
    unique case (state_d)
      StClkSw:  clk_sel_d = 1'b1;
      StGate:   clk_en_d  = 1'b0;
      StIso:    iso_en_d  = 1'b1;
      StSwOff:  sw_en_d   = 1'b0;
      StOff:    sw_en_d   = 1'b0;
      StSwOn:   sw_en_d   = 1'b1;
      StDeiso:  iso_en_d  = 1'b0;
      StUngate: clk_en_d  = 1'b1;
      StOn:     clk_sel_d = 1'b0;
      default: ;
    endcase
  end

  assign bus.clk_sel     = clk_sel_q;
  assign bus.clk_en      = clk_en_q;
  assign bus.iso_en      = iso_en_q;
  assign bus.ret_save    = ret_save_q;
  assign bus.ret_restore = ret_restore_q;
  assign bus.sw_en       = sw_en_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;

endmodule
